// File: rtl/rv_data_arb.sv
// Two-master round-robin arbiter for the shared data memory port.
// One transaction in flight; the response goes back to the owning master, and a watchdog forces an error completion.
module rv_data_arb #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     TIMEOUT_CYCLES = 256,
  parameter logic [XLEN-1:0] TO_RDATA       = 32'hDEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [XLEN/8-1:0] m0_be_i,
  input  logic [XLEN-1:0]   m0_addr_i,
  input  logic [XLEN-1:0]   m0_wdata_i,
  output logic              m0_rvalid_o,
  output logic [XLEN-1:0]   m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [XLEN/8-1:0] m1_be_i,
  input  logic [XLEN-1:0]   m1_addr_i,
  input  logic [XLEN-1:0]   m1_wdata_i,
  output logic              m1_rvalid_o,
  output logic [XLEN-1:0]   m1_rdata_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i,
  output logic              busy_o,
  output logic              timeout_o
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner;
  logic                r_last_gnt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic [XLEN/8-1:0]   r_be;
  logic [XLEN-1:0]     r_addr;
  logic [XLEN-1:0]     r_wdata;

  logic                w_any_req;
  logic                w_win;
  logic                w_done;
  logic                w_to;
  logic                w_cmpl;
  logic                w_rv0;
  logic                w_rv1;
  logic [XLEN-1:0]     w_rdata;

  assign w_any_req = m0_req_i | m1_req_i;
  // On a tie the master that did not win last time gets the port.
  assign w_win     = (m0_req_i & m1_req_i) ? ~r_last_gnt : m1_req_i;

  assign w_done = (r_state != S_IDLE) & data_rvalid_i;
  assign w_to   = (r_state == S_WAIT) & ~data_rvalid_i &
                  (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_cmpl = w_done | w_to;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = data_rvalid_i ? S_IDLE : S_WAIT;
      S_WAIT:  if (w_cmpl) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_last_gnt <= 1'b1;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any_req) begin
        r_owner <= w_win;
        r_we    <= w_win ? m1_we_i    : m0_we_i;
        r_be    <= w_win ? m1_be_i    : m0_be_i;
        r_addr  <= w_win ? m1_addr_i  : m0_addr_i;
        r_wdata <= w_win ? m1_wdata_i : m0_wdata_i;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= CNT_W'(1);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_cmpl) r_last_gnt <= r_owner;
    end
  end

  assign data_req_o   = (r_state == S_ISSUE);
  assign data_we_o    = r_we;
  assign data_be_o    = r_be;
  assign data_addr_o  = r_addr;
  assign data_wdata_o = r_wdata;

  // Response path is combinational so the owner sees rvalid in the same cycle as downstream.
  assign w_rdata     = w_to ? TO_RDATA : data_rdata_i;
  assign w_rv0       = w_cmpl & ~r_owner;
  assign w_rv1       = w_cmpl &  r_owner;
  assign m0_rvalid_o = w_rv0;
  assign m1_rvalid_o = w_rv1;
  assign m0_rdata_o  = w_rv0 ? w_rdata : '0;
  assign m1_rdata_o  = w_rv1 ? w_rdata : '0;
  assign busy_o      = (r_state != S_IDLE);
  assign timeout_o   = w_to;
endmodule

// File: tb/tb_rv_data_arb.sv
// Bench for rv_data_arb: table of single-master transactions plus hand-written
// sequences for arbitration, watchdog, mid-transaction reset and stray responses.
module tb_rv_data_arb;
  localparam int TO    = 8;
  localparam int NEVER = 255;

  typedef struct {
    bit          m;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    bit          to;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        m0_req_i = 0, m0_we_i = 0, m1_req_i = 0, m1_we_i = 0;
  logic [3:0]  m0_be_i = 0, m1_be_i = 0;
  logic [31:0] m0_addr_i = 0, m0_wdata_i = 0, m1_addr_i = 0, m1_wdata_i = 0;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'h0;
  logic        busy_o, timeout_o;

  initial forever #5 clk = ~clk;

  rv_data_arb #(.XLEN(32), .TIMEOUT_CYCLES(TO), .TO_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  vec_t        exp_q[$];
  vec_t        mq0[$];
  vec_t        mq1[$];
  vec_t        vecs[7];
  int          n_vec = 0, n_err = 0, cyc = 0, issue_cyc = 0, mcnt = 0, req_cyc = 0;
  logic [31:0] mrd = 32'h0;
  bit          stray = 0, prev_dreq = 0, prev_rv = 0, rv0_now = 0, rv1_now = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic monitor();
    vec_t e;
    rv0_now = m0_rvalid_o;
    rv1_now = m1_rvalid_o;
    if (data_req_o) begin
      chk("dreq_single", 64'(prev_dreq), 0);
      chk("busy_issue", 64'(busy_o), 1);
      issue_cyc = cyc;
      if (exp_q.size() == 0) chk("dreq_unexpected", 1, 0);
      else begin
        chk("dreq_we_be_addr", {data_we_o, data_be_o, data_addr_o},
            {exp_q[0].we, exp_q[0].be, exp_q[0].addr});
        chk("dreq_wdata", 64'(data_wdata_o), 64'(exp_q[0].wdata));
      end
    end
    prev_dreq = data_req_o;
    if (prev_rv) chk("idle_after_cmpl", 64'(busy_o), 0);
    prev_rv = rv0_now | rv1_now;
    chk("rdata0_gated", 64'(!m0_rvalid_o && m0_rdata_o != 0), 0);
    chk("rdata1_gated", 64'(!m1_rvalid_o && m1_rdata_o != 0), 0);
    if (rv0_now || rv1_now) begin
      if (exp_q.size() == 0) chk("rvalid_unexpected", {rv1_now, rv0_now}, 0);
      else begin
        e = exp_q.pop_front();
        chk("rv_owner", {rv1_now, rv0_now}, e.m ? 2'b10 : 2'b01);
        chk("rv_rdata", 64'(e.m ? m1_rdata_o : m0_rdata_o), 64'(e.rdata));
        chk("rv_timeout", 64'(timeout_o), 64'(e.to));
        chk("rv_latency", 64'(cyc - issue_cyc), 64'(e.to ? TO - 1 : e.lat));
      end
    end else begin
      chk("timeout_quiet", 64'(timeout_o), 0);
    end
  endtask

  // One clock: downstream memory reacts just after the edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    data_rvalid_i = 1'b0;
    data_rdata_i  = 32'h0BAD_F00D;
    if (stray) begin
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h5555_AAAA;
    end
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = mrd;
      end
    end
    if (data_req_o && exp_q.size() > 0) begin
      mrd = exp_q[0].rdata;
      if (exp_q[0].lat == 0) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = mrd;
      end else if (exp_q[0].lat < NEVER) begin
        mcnt = exp_q[0].lat;
      end
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic drive_reqs();
    m0_req_i = (mq0.size() > 0);
    m1_req_i = (mq1.size() > 0);
    {m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i} = m0_req_i ?
      {mq0[0].we, mq0[0].be, mq0[0].addr, mq0[0].wdata} : 69'h0;
    {m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i} = m1_req_i ?
      {mq1[0].we, mq1[0].be, mq1[0].addr, mq1[0].wdata} : 69'h0;
  endtask

  task automatic run(input int budget);
    int n = 0;
    drive_reqs();
    while ((mq0.size() > 0 || mq1.size() > 0) && n < budget) begin
      tick();
      n++;
      if (rv0_now && mq0.size() > 0) mq0.delete(0);
      if (rv1_now && mq1.size() > 0) mq1.delete(0);
      drive_reqs();
    end
    chk("run_pending", 64'(mq0.size() + mq1.size()), 0);
    if (mq0.size() > 0 || mq1.size() > 0) begin
      mq0.delete();
      mq1.delete();
      exp_q.delete();
      drive_reqs();
    end
    tick();
  endtask

  task automatic push(input vec_t v);
    exp_q.push_back(v);
    if (v.m) mq1.push_back(v);
    else mq0.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    push(v);
    req_cyc = cyc;
    run(40);
    chk("req_latency", 64'(issue_cyc), 64'(req_cyc + 1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {m0_rvalid_o, m1_rvalid_o, data_req_o, data_we_o, data_be_o,
                         busy_o, timeout_o}, 0);
    chk({tag, "_addr_wdata"}, {data_addr_o, data_wdata_o}, 0);
    chk({tag, "_rdata"}, {m0_rdata_o, m1_rdata_o}, 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    mq0.delete();
    mq1.delete();
    exp_q.delete();
    drive_reqs();
    mcnt = 0;
    tick();
    check_all_zero("reset");
    rst_ni = 1'b1;
    prev_dreq = 0;
    prev_rv   = 0;
  endtask

  initial begin
    vec_t v;
    //            m   we  be     addr          wdata         rdata         lat    to
    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'h1234_5678, 1,     1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h8000_0000, 32'hAAAA_5555, 32'h0,        0,     1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,        3,     1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0,        32'h89AB_CDEF, 2,     1'b0};
    vecs[4] = '{1'b0, 1'b0, 4'hF, 32'h0000_0300, 32'h0,        32'hDEAD_BEEF, NEVER, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h0000_0304, 32'h0,        32'h0F0F_0F0F, 1,     1'b0};
    vecs[6] = '{1'b1, 1'b0, 4'h8, 32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFFF, 5,     1'b0};

    do_reset();
    tick();
    for (int i = 0; i < 7; i++) apply(vecs[i]);

    // Simultaneous requests straight out of reset: m0 first, then m1.
    do_reset();
    push('{1'b0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 32'h1111_0000, 1, 1'b0});
    push('{1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 32'h2222_0000, 1, 1'b0});
    run(30);

    // Both requesting continuously: strict alternation over six transactions.
    for (int i = 0; i < 6; i++) begin
      v = '{bit'(i % 2), 1'b0, 4'hF, 32'h0000_3000 + 32'(i * 4), 32'h0,
            32'h3300_0000 + 32'(i), 1, 1'b0};
      push(v);
    end
    run(60);

    // Reset during WAIT abandons the transaction; a later stray response is ignored.
    do_reset();
    v = '{1'b0, 1'b0, 4'hF, 32'h0000_0400, 32'h0, 32'h0, NEVER, 1'b0};
    push(v);
    drive_reqs();
    tick();
    chk("abandon_issue", 64'(data_req_o), 1);
    tick();
    chk("abandon_wait", {busy_o, data_req_o, data_addr_o}, {1'b1, 1'b0, 32'h0000_0400});
    rst_ni = 1'b0;
    mq0.delete();
    drive_reqs();
    tick();
    check_all_zero("rst_mid");
    rst_ni = 1'b1;
    exp_q.delete();
    prev_rv = 0;
    tick();
    stray = 1;
    tick();
    stray = 0;
    chk("stray_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
    chk("stray_busy", 64'(busy_o), 0);
    tick();
    chk("stray_stays_idle", 64'(busy_o), 0);
    apply('{1'b1, 1'b0, 4'hF, 32'h0000_0500, 32'h0, 32'h7777_8888, 1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
